// File: rtl/alu_pkg.sv
`default_nettype none
// alu_pkg: opcode values and FSM encoding shared by the multi-cycle ALU.
// Revision 1.0
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;
  localparam logic [3:0] ALU_NOR = 4'd12;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_shift_add_mul.sv
`default_nettype none
// alu_shift_add_mul: unsigned iterative shift-add multiplier, one multiplier bit per edge.
// Revision 1.0
module alu_shift_add_mul #(
  parameter int WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] addend;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      count_q, count_d;

  // The first multiplier bit is consumed on the start edge itself, so the
  // counter holds the bits still outstanding and the last one lands exactly
  // WIDTH-1 edges later.
  always_comb begin
    addend   = mplier_q[0] ? mcand_q : '0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    if (start) begin
      acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand_d  = {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier_d = {1'b0, b[WIDTH-1:1]};
      count_d  = CW'(WIDTH-1);
    end else if (busy) begin
      acc_d    = acc_q + addend;
      mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
      count_d  = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
    end
  end

  assign busy    = (count_q != '0);
  assign done    = (count_q == CW'(1));
  assign product = acc_d;

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// alu_mc: registered execute-stage ALU with valid/ready handshake and multi-cycle MUL.
// Revision 1.0
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SIGNED_SLT = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             zero_o,
  output logic             overflow_o
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             overflow_q, overflow_d;
  logic             valid_q, valid_d;

  logic             accept;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH-1:0] sum, diff, op_result;
  logic             op_overflow, slt_lt;

  assign accept    = valid_i && (state_q == ST_IDLE);
  assign mul_start = accept && (ctrl_i == ALU_MUL);

  alu_shift_add_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start  (mul_start),
    .a      (src1_i),
    .b      (src2_i),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );

  always_comb begin
    sum         = src1_i + src2_i;
    diff        = src1_i - src2_i;
    slt_lt      = (SIGNED_SLT != 0) ? ($signed(src1_i) < $signed(src2_i))
                                    : (src1_i < src2_i);
    op_result   = '0;
    op_overflow = 1'b0;
    case (ctrl_i)
      ALU_AND: op_result = src1_i & src2_i;
      ALU_OR:  op_result = src1_i | src2_i;
      ALU_NOR: op_result = ~(src1_i | src2_i);
      ALU_SLT: op_result = {{(WIDTH-1){1'b0}}, slt_lt};
      ALU_ADD: begin
        op_result   = sum;
        op_overflow = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) &&
                      (sum[WIDTH-1] != src1_i[WIDTH-1]);
      end
      ALU_SUB: begin
        op_result   = diff;
        op_overflow = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) &&
                      (diff[WIDTH-1] != src1_i[WIDTH-1]);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    overflow_d  = overflow_q;
    valid_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (ctrl_i == ALU_MUL) begin
            state_d = ST_MUL;
          end else begin
            result_d    = op_result;
            result_hi_d = '0;
            overflow_d  = op_overflow;
            valid_d     = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          result_d    = mul_product[WIDTH-1:0];
          result_hi_d = mul_product[2*WIDTH-1:WIDTH];
          overflow_d  = 1'b0;
          valid_d     = 1'b1;
          state_d     = ST_IDLE;
        end else if (!mul_busy) begin
          // Multiplier idle without a completion: recover rather than stall forever.
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      overflow_q  <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      overflow_q  <= overflow_d;
      valid_q     <= valid_d;
    end
  end

  assign ready_o     = (state_q == ST_IDLE);
  assign valid_o     = valid_q;
  assign result_o    = result_q;
  assign result_hi_o = result_hi_q;
  assign overflow_o  = overflow_q;
  assign zero_o      = (result_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// tb_alu_mc: randomized self-checking bench for alu_mc against an arithmetic reference model.
// Revision 1.0
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        valid8_i;
  logic [31:0] src1_i, src2_i;
  logic [3:0]  ctrl_i;

  logic        u0_ready, u0_valid, u0_zero, u0_ovf;
  logic [31:0] u0_res, u0_hi;
  logic        u1_ready, u1_valid, u1_zero, u1_ovf;
  logic [31:0] u1_res, u1_hi;
  logic        u8_ready, u8_valid, u8_zero, u8_ovf;
  logic [7:0]  u8_res, u8_hi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32), .SIGNED_SLT(0)) u_dut_u (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(u0_ready),
    .src1_i(src1_i), .src2_i(src2_i), .ctrl_i(ctrl_i), .valid_o(u0_valid),
    .result_o(u0_res), .result_hi_o(u0_hi), .zero_o(u0_zero), .overflow_o(u0_ovf)
  );

  alu_mc #(.WIDTH(32), .SIGNED_SLT(1)) u_dut_s (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(u1_ready),
    .src1_i(src1_i), .src2_i(src2_i), .ctrl_i(ctrl_i), .valid_o(u1_valid),
    .result_o(u1_res), .result_hi_o(u1_hi), .zero_o(u1_zero), .overflow_o(u1_ovf)
  );

  alu_mc #(.WIDTH(8), .SIGNED_SLT(0)) u_dut_8 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid8_i), .ready_o(u8_ready),
    .src1_i(src1_i[7:0]), .src2_i(src2_i[7:0]), .ctrl_i(ctrl_i), .valid_o(u8_valid),
    .result_o(u8_res), .result_hi_o(u8_hi), .zero_o(u8_zero), .overflow_o(u8_ovf)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: signed values held as 64-bit integers, overflow = wrapped result
  // no longer equals the true mathematical result.
  function automatic void ref_alu(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                                  input bit sslt, output logic [31:0] lo, output logic [31:0] hi,
                                  output logic ovf);
    longint      sa, sb, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lo  = 32'd0;
    hi  = 32'd0;
    ovf = 1'b0;
    case (ctrl)
      4'd0:  lo = a & b;
      4'd1:  lo = a | b;
      4'd12: lo = ~(a | b);
      4'd2: begin
        r = sa + sb;  lo = a + b;
        ovf = (r != longint'($signed(lo)));
      end
      4'd6: begin
        r = sa - sb;  lo = a - b;
        ovf = (r != longint'($signed(lo)));
      end
      4'd7: lo = (sslt ? (sa < sb) : (a < b)) ? 32'd1 : 32'd0;
      4'd8: begin
        p  = 64'(a) * 64'(b);
        lo = p[31:0];
        hi = p[63:32];
      end
      default: ;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where the pulse is seen (plus one if gap).
  task automatic run_op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        input bit stray, input bit gap);
    logic [31:0] e_lo, e_hi, s_lo, s_hi;
    logic        e_ovf, s_ovf;
    int          n;
    bit          busy_ok;
    ref_alu(ctrl, a, b, 1'b0, e_lo, e_hi, e_ovf);
    ref_alu(ctrl, a, b, 1'b1, s_lo, s_hi, s_ovf);
    check_eq("ready_before_op", 64'(u0_ready), 64'd1);
    valid_i = 1'b1; ctrl_i = ctrl; src1_i = a; src2_i = b;
    n = 0; busy_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (!u0_valid) begin
        if (u0_ready || u1_ready) busy_ok = 1'b0;
        src1_i  = $urandom;
        src2_i  = $urandom;
        ctrl_i  = 4'd2;
        valid_i = stray;
      end
    end while (!u0_valid && n < 100);
    valid_i = 1'b0;
    check_eq("latency", 64'(n), (ctrl == 4'd8) ? 64'd32 : 64'd1);
    if (ctrl == 4'd8) check_eq("ready_low_while_busy", 64'(busy_ok), 64'd1);
    check_eq("u_lo",       64'(u0_res),   64'(e_lo));
    check_eq("u_hi",       64'(u0_hi),    64'(e_hi));
    check_eq("u_ovf",      64'(u0_ovf),   64'(e_ovf));
    check_eq("u_zero",     64'(u0_zero),  64'(e_lo == 32'd0));
    check_eq("u_ready",    64'(u0_ready), 64'd1);
    check_eq("s_valid",    64'(u1_valid), 64'd1);
    check_eq("s_lo",       64'(u1_res),   64'(s_lo));
    check_eq("s_hi",       64'(u1_hi),    64'(s_hi));
    check_eq("s_ovf",      64'(u1_ovf),   64'(s_ovf));
    if (gap) begin
      @(negedge clk);
      check_eq("pulse_one_cycle", 64'(u0_valid), 64'd0);
      check_eq("hold_lo",         64'(u0_res),   64'(e_lo));
      check_eq("hold_hi",         64'(u0_hi),    64'(e_hi));
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0]  ops  [4] = '{4'd0, 4'd1, 4'd12, 4'd5};
    logic [31:0] exps [4] = '{32'h00F0_00F0, 32'hFFF0_FFF0, 32'h000F_000F, 32'h0};
    logic [3:0]  ctrl_set [10] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd12, 4'd3, 4'd5, 4'd15};
    int          n;
    bit          seen;

    rst_i = 1'b0; valid_i = 1'b0; valid8_i = 1'b0;
    src1_i = '0; src2_i = '0; ctrl_i = '0;
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    check_eq("rst_valid", 64'(u0_valid), 64'd0);
    check_eq("rst_lo",    64'(u0_res),   64'd0);
    check_eq("rst_hi",    64'(u0_hi),    64'd0);
    check_eq("rst_ovf",   64'(u0_ovf),   64'd0);
    check_eq("rst_zero",  64'(u0_zero),  64'd1);
    check_eq("rst_ready", 64'(u0_ready), 64'd1);

    run_op(4'd2, 32'd5, 32'd7, 1'b0, 1'b1);
    run_op(4'd6, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check_eq("sub_ovf_lo", 64'(u0_res), 64'h8000_0000);
    check_eq("sub_ovf",    64'(u0_ovf), 64'd1);
    run_op(4'd2, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    check_eq("add_wrap_zero", 64'(u0_zero), 64'd1);
    run_op(4'd7, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    check_eq("slt_unsigned", 64'(u0_res), 64'd0);
    check_eq("slt_signed",   64'(u1_res), 64'd1);

    run_op(4'd8, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b1);
    run_op(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check_eq("mul_max_lo", 64'(u0_res), 64'h1);
    check_eq("mul_max_hi", 64'(u0_hi),  64'hFFFF_FFFE);

    // Back-to-back single-cycle ops, one accept per edge.
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        check_eq("b2b_valid", 64'(u0_valid), 64'd1);
        check_eq("b2b_lo",    64'(u0_res),   64'(exps[i-1]));
        check_eq("b2b_hi",    64'(u0_hi),    64'd0);
      end
      if (i < 4) begin
        valid_i = 1'b1; ctrl_i = ops[i];
        src1_i = 32'hF0F0_F0F0; src2_i = 32'h0FF0_0FF0;
      end else begin
        valid_i = 1'b0;
      end
      @(negedge clk);
    end
    check_eq("b2b_end_valid", 64'(u0_valid), 64'd0);

    // Reset during MUL.
    valid_i = 1'b1; ctrl_i = 4'd8; src1_i = 32'd3; src2_i = 32'd5;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (9) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    check_eq("mulrst_valid", 64'(u0_valid), 64'd0);
    check_eq("mulrst_lo",    64'(u0_res),   64'd0);
    check_eq("mulrst_hi",    64'(u0_hi),    64'd0);
    check_eq("mulrst_zero",  64'(u0_zero),  64'd1);
    check_eq("mulrst_ready", 64'(u0_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (u0_valid) seen = 1'b1;
    end
    check_eq("mulrst_no_pulse", 64'(seen), 64'd0);
    run_op(4'd2, 32'd1, 32'd1, 1'b0, 1'b0);
    check_eq("post_rst_add", 64'(u0_res), 64'd2);

    // Narrow build.
    valid8_i = 1'b1; ctrl_i = 4'd8; src1_i = 32'hFF; src2_i = 32'h02;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      valid8_i = 1'b0;
    end while (!u8_valid && n < 50);
    check_eq("w8_latency", 64'(n),      64'd8);
    check_eq("w8_lo",      64'(u8_res), 64'hFE);
    check_eq("w8_hi",      64'(u8_hi),  64'h01);
    check_eq("w8_ready",   64'(u8_ready), 64'd1);
    valid8_i = 1'b1; ctrl_i = 4'd2; src1_i = 32'h7F; src2_i = 32'h01;
    @(negedge clk);
    valid8_i = 1'b0;
    check_eq("w8_add_valid", 64'(u8_valid), 64'd1);
    check_eq("w8_add_lo",    64'(u8_res),   64'h80);
    check_eq("w8_add_ovf",   64'(u8_ovf),   64'd1);
    check_eq("w8_add_zero",  64'(u8_zero),  64'd0);

    for (int k = 0; k < 150; k++) begin
      run_op(ctrl_set[$urandom_range(0, 9)], pick_operand(), pick_operand(),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Registered, parametrised successor to the single-cycle CPU ALU, for the pipelined CPU execute stage.
- Keeps the existing ctrl encodings and adds three things:
  - a valid/ready handshake;
  - an iterative shift-add multiplier with full double-width product;
  - a signed-overflow flag and selectable signed/unsigned SLT.
- Single-cycle ops complete in 1 cycle. MUL takes WIDTH cycles; the pipeline stalls on ready_o.

Parameters:
- WIDTH, 32, operand/result width; legal range 4..64.
- SIGNED_SLT, 0, 0 = unsigned compare for SLT (legacy behaviour), 1 = two's-complement compare.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; synchronous, active-low.
- valid_i  input  1  operation request.
- ready_o  output  1  block can accept a request this cycle.
- src1_i  input  WIDTH  operand A.
- src2_i  input  WIDTH  operand B.
- ctrl_i  input  4  opcode: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 8 MUL, 12 NOR.
- valid_o  output  1  one-cycle pulse: result_o, result_hi_o and overflow_o are new.
- result_o  output  WIDTH  result (low word for MUL).
- result_hi_o  output  WIDTH  MUL upper word; 0 for every other op.
- zero_o  output  1  (result_o == 0).
- overflow_o  output  1  signed overflow for ADD/SUB; 0 otherwise.

Behaviour:
- Reset (rst_i=0 at a rising edge):
  - state IDLE; result_o=0, result_hi_o=0, overflow_o=0, valid_o=0, ready_o=1; zero_o therefore 1.
  - Reset overrides all other inputs.
- Accept: a request is accepted at the edge where valid_i=1 and ready_o=1. Inputs are sampled only at that edge.
- FSM states: IDLE, MUL.
  - IDLE, accept non-MUL op: next cycle result registered, valid_o=1, state stays IDLE, ready_o stays 1. Back-to-back accepts every cycle are legal.
  - IDLE, accept MUL:
    - load multiplicand, multiplier and count=WIDTH; clear the 2*WIDTH accumulator.
    - go to MUL; ready_o=0 from the next cycle.
  - MUL: each edge processes one multiplier bit (LSB first) and decrements count.
    - At the edge where count reaches 0: register result_o = product[WIDTH-1:0], result_hi_o = product[2W-1:W], set valid_o=1, return to IDLE (ready_o=1 in that same cycle).
    - MUL latency is therefore exactly WIDTH edges from the accept edge.
    - MUL is unsigned; overflow_o=0.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - overflow_o = operands' signs equal (ADD) / differ (SUB) AND result sign differs from src1 sign.
  - SLT yields 1 or 0; compare is signed iff SIGNED_SLT=1.
  - NOR is ~(A|B).
- Unknown ctrl: result_o=0, result_hi_o=0, overflow_o=0, valid_o pulses normally (latency 1).
- valid_o is high for exactly one cycle per accepted request, never otherwise.
- Outputs hold their last values between pulses.
- valid_i while ready_o=0 is ignored: no queueing, no error.
- Reset during MUL: operation aborted, no valid_o pulse, reset values from the next cycle.
- Accept in the same cycle as a MUL completion pulse is legal.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLT=7, ALU_MUL=8, ALU_NOR=12;
  - FSM state encoding.
- One sub-module, alu_shift_add_mul:
  - ports clk_i, rst_i, start, a, b → busy, done, product[2W-1:0].
  - contains the counter and accumulator.
- alu_mc owns the handshake, the combinational ops and the output registers.

Test Plan (WIDTH=32 unless stated):
1. Reset, then ADD 5+7 → one cycle later valid_o=1, result_o=12, zero_o=0, overflow_o=0; after reset release and before any op, zero_o=1.
2. SUB 0x7FFFFFFF−0xFFFFFFFF → result_o=0x80000000, overflow_o=1. ADD 0xFFFFFFFF+1 → result_o=0, zero_o=1, overflow_o=0.
3. SLT src1=0xFFFFFFFF, src2=1: SIGNED_SLT=0 → 0; SIGNED_SLT=1 → 1.
4. MUL 0x00010000×0x00010000:
   - ready_o=0 for 31 cycles after the accept edge;
   - valid_o high exactly 32 edges after accept, with result_o=0, result_hi_o=1, zero_o=1;
   - an ADD presented with valid_i=1 during busy produces no pulse.
   - Also check MUL 0xFFFFFFFF×0xFFFFFFFF → lo=0x00000001, hi=0xFFFFFFFE.
5. Back-to-back AND, OR, NOR, ctrl=5 on A=0xF0F0F0F0, B=0x0FF00FF0, one per cycle:
   - four consecutive valid_o pulses;
   - results 0x00F000F0, 0xFFF0FFF0, 0x000F000F, 0.
6. rst_i=0 for one cycle at cycle 10 of a MUL → no valid_o pulse, outputs at reset values, ready_o=1; the following ADD 1+1 → result_o=2 after 1 cycle.
7. WIDTH=8 build: MUL 0xFF×0x02 → lo=0xFE, hi=0x01, latency 8.
